// File: rtl/timer_alarm_ctrl.sv
// timer_alarm_ctrl
//   Compare/alarm controller for the free-running 64-bit cycle timer.
//   Raises a level interrupt when time reaches a 64-bit compare value,
//   optionally re-arms by adding PERIOD, and offers a tear-free 64-bit
//   time snapshot for 32-bit readers.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   time_i[63:0]        current timer value
//   req_i/we_i/addr_i/wdata_i  single-cycle register access
//   ack_o/rdata_o       registered response, one cycle after req_i
//   irq_o               alarm pending (PEND), registered level
module timer_alarm_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] time_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    FIRED    = 2'd2
  } state_t;

  localparam logic [2:0]  A_CTRL    = 3'd0;
  localparam logic [2:0]  A_CMP_LO  = 3'd1;
  localparam logic [2:0]  A_CMP_HI  = 3'd2;
  localparam logic [2:0]  A_PERIOD  = 3'd3;
  localparam logic [2:0]  A_TIME_LO = 3'd4;
  localparam logic [2:0]  A_TIME_HI = 3'd5;
  localparam logic [2:0]  A_FIRECNT = 3'd6;
  localparam logic [2:0]  A_ID      = 3'd7;
  localparam logic [31:0] ID_VAL    = 32'h544D_5231;

  state_t      state;
  logic        en, periodic, pend;
  logic [63:0] cmp;
  logic [31:0] shadow_lo, period, snap, fire_cnt;

  logic        wr, rd, wr_ctrl, wr_lo, wr_hi, wr_per, wr_cnt, rd_tlo;
  logic        fire, en_nxt;
  logic [31:0] rd_mux;

  assign wr      = req_i & we_i;
  assign rd      = req_i & ~we_i;
  assign wr_ctrl = wr && (addr_i == A_CTRL);
  assign wr_lo   = wr && (addr_i == A_CMP_LO);
  assign wr_hi   = wr && (addr_i == A_CMP_HI);
  assign wr_per  = wr && (addr_i == A_PERIOD);
  assign wr_cnt  = wr && (addr_i == A_FIRECNT);
  assign rd_tlo  = rd && (addr_i == A_TIME_LO);

  // Fire decision uses the time sample at this edge against the live cmp.
  assign fire    = (state == ARMED) && (time_i >= cmp);
  // State follows the EN value that will hold after this edge, so enabling
  // arms at the write edge and the first fire is evaluated one edge later.
  assign en_nxt  = wr_ctrl ? wdata_i[0] : en;

  assign irq_o   = pend;

  always_comb begin
    rd_mux = '0;
    case (addr_i)
      A_CTRL:    rd_mux = {27'b0, state, pend, periodic, en};
      A_CMP_LO:  rd_mux = cmp[31:0];
      A_CMP_HI:  rd_mux = cmp[63:32];
      A_PERIOD:  rd_mux = period;
      A_TIME_LO: rd_mux = time_i[31:0];
      A_TIME_HI: rd_mux = snap;
      A_FIRECNT: rd_mux = fire_cnt;
      A_ID:      rd_mux = ID_VAL;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_o     <= 1'b0;
      rdata_o   <= '0;
      state     <= DISABLED;
      en        <= 1'b0;
      periodic  <= 1'b0;
      pend      <= 1'b0;
      cmp       <= '1;
      shadow_lo <= '0;
      period    <= '0;
      snap      <= '0;
      fire_cnt  <= '0;
    end else begin
      ack_o   <= req_i;
      rdata_o <= rd ? rd_mux : '0;

      if (wr_ctrl) begin
        en       <= wdata_i[0];
        periodic <= wdata_i[1];
      end

      // A fire beats a same-cycle W1C of PEND.
      if (fire)                        pend <= 1'b1;
      else if (wr_ctrl && wdata_i[2])  pend <= 1'b0;

      if (wr_lo)  shadow_lo <= wdata_i;
      if (wr_per) period    <= wdata_i;

      // A CMP_HI write beats the periodic reload in the same cycle.
      if (wr_hi)                  cmp <= {wdata_i, shadow_lo};
      else if (fire && periodic)  cmp <= cmp + {32'b0, period};

      // Upper half captured from the same sample that returns the lower half.
      if (rd_tlo) snap <= time_i[63:32];

      if (wr_cnt)     fire_cnt <= fire ? 32'd1 : 32'd0;
      else if (fire)  fire_cnt <= fire_cnt + 32'd1;

      if (!en_nxt) state <= DISABLED;
      else begin
        case (state)
          DISABLED: state <= ARMED;
          ARMED:    if (!wr_hi && fire && !periodic) state <= FIRED;
          FIRED:    if (wr_hi) state <= ARMED;
          default:  state <= DISABLED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_alarm_ctrl.sv
// Bench for timer_alarm_ctrl: directed test-plan steps followed by a
// randomized phase, every cycle checked against a rule-level model.
module tb_timer_alarm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] time_v = '0;
  logic        req = 1'b0, we = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        ack, irq;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;

  timer_alarm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .time_i(time_v),
    .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack), .rdata_o(rdata), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Reference model state (DISABLED=0, ARMED=1, FIRED=2)
  bit          m_en, m_per, m_pend;
  int          m_state;
  logic [63:0] m_cmp;
  logic [31:0] m_sh, m_period, m_snap, m_cnt;
  logic        e_ack;
  logic [31:0] e_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of the block, described as: respond to the access,
  // apply the fire, then let register writes override, then apply EN.
  task automatic model(input logic rs, input logic rq, input logic w,
                       input logic [2:0] a, input logic [31:0] d, input logic [63:0] t);
    bit fired;
    if (!rs) begin
      m_en = 0; m_per = 0; m_pend = 0; m_state = 0;
      m_cmp = '1; m_sh = 0; m_period = 0; m_snap = 0; m_cnt = 0;
      e_ack = 0; e_rd = 0;
      return;
    end
    e_ack = rq;
    e_rd  = 0;
    if (rq && !w) begin
      case (a)
        3'd0: e_rd = {27'b0, 2'(m_state), m_pend, m_per, m_en};
        3'd1: e_rd = m_cmp[31:0];
        3'd2: e_rd = m_cmp[63:32];
        3'd3: e_rd = m_period;
        3'd4: begin e_rd = t[31:0]; m_snap = t[63:32]; end
        3'd5: e_rd = m_snap;
        3'd6: e_rd = m_cnt;
        default: e_rd = 32'h544D_5231;
      endcase
    end
    fired = (m_state == 1) && (t >= m_cmp);
    if (fired) begin
      m_pend = 1;
      m_cnt  = m_cnt + 1;
      if (m_per) m_cmp = m_cmp + {32'b0, m_period};
      else       m_state = 2;
    end
    if (rq && w) begin
      case (a)
        3'd0: begin
          m_en = d[0]; m_per = d[1];
          if (d[2] && !fired) m_pend = 0;
        end
        3'd1: m_sh = d;
        3'd2: begin m_cmp = {d, m_sh}; m_state = 1; end
        3'd3: m_period = d;
        3'd6: m_cnt = fired ? 32'd1 : 32'd0;
        default: ;
      endcase
    end
    if (!m_en)              m_state = 0;
    else if (m_state == 0)  m_state = 1;
  endtask

  task automatic tick(input logic rs, input logic rq, input logic w,
                      input logic [2:0] a, input logic [31:0] d, input logic [63:0] t);
    rst_n = rs; req = rq; we = w; addr = a; wdata = d; time_v = t;
    @(posedge clk);
    model(rs, rq, w, a, d, t);
    #1;
    chk("ack", ack, e_ack);
    chk("rdata", rdata, e_rd);
    chk("irq", irq, m_pend);
    req = 0; we = 0; rst_n = 1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [63:0] t);
    tick(1, 1, 1, a, d, t);
  endtask

  task automatic rd(input logic [2:0] a, input logic [63:0] t);
    tick(1, 1, 0, a, 0, t);
  endtask

  task automatic idle(input logic [63:0] t);
    tick(1, 0, 0, 0, 0, t);
  endtask

  initial begin
    logic [63:0] tv;
    logic [31:0] d;
    logic [2:0]  a;
    logic        rs, rq, w;
    int          r;

    // Reset, with a read request dropped by reset
    tick(0, 1, 0, 3'd7, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_irq", irq, 0);
    rd(0, 0); chk("rst_ctrl", rdata, 0);
    rd(1, 0); chk("rst_cmp_lo", rdata, 32'hFFFF_FFFF);
    rd(2, 0); chk("rst_cmp_hi", rdata, 32'hFFFF_FFFF);
    rd(7, 0); chk("id", rdata, 32'h544D_5231);

    // One-shot
    wr(1, 100, 0); wr(2, 0, 0); wr(0, 1, 0);
    for (int t = 90; t <= 105; t++) begin
      idle(64'(t));
      chk("os_irq", irq, (t >= 100));
    end
    rd(0, 105); chk("os_ctrl", rdata, 32'h15);
    rd(6, 105); chk("os_cnt", rdata, 1);
    wr(0, 5, 105); chk("os_clr", irq, 0);
    for (int t = 106; t <= 110; t++) begin
      idle(64'(t));
      chk("os_norefire", irq, 0);
    end

    // Periodic
    wr(6, 0, 110); wr(3, 50, 110); wr(1, 1000, 110); wr(2, 0, 110); wr(0, 3, 110);
    for (int t = 990; t <= 1120; t++) idle(64'(t));
    rd(6, 1120); chk("per_cnt", rdata, 3);
    rd(1, 1120); chk("per_cmp", rdata, 1150);
    for (int i = 0; i < 6; i++) idle(1300);
    rd(6, 1300); chk("catchup_cnt", rdata, 7);
    rd(1, 1300); chk("catchup_cmp", rdata, 1350);

    // Atomic CMP update
    wr(1, 5, 10);
    rd(6, 10); chk("atom_nofire", rdata, 7);
    wr(2, 1, 10);
    rd(1, 10); chk("atom_lo", rdata, 5);
    rd(2, 10); chk("atom_hi", rdata, 1);
    rd(6, 10); chk("atom_cnt", rdata, 7);

    // Collisions
    wr(0, 7, 10); chk("pend_clr", irq, 0);
    wr(0, 7, 64'h1_0000_0005); chk("fire_vs_clr", irq, 1);
    wr(6, 0, 64'h1_0000_0037);
    rd(6, 64'h1_0000_0037); chk("fire_vs_cntwr", rdata, 1);
    wr(0, 2, 0);
    rd(0, 0); chk("dis_ctrl", rdata, 32'h6);
    for (int i = 0; i < 4; i++) idle(64'h1_0000_1000);
    rd(6, 64'h1_0000_1000); chk("dis_nofire", rdata, 1);

    // Snapshot
    rd(4, 64'h1_FFFF_FFFF); chk("snap_lo", rdata, 32'hFFFF_FFFF);
    rd(5, 64'h2_0000_0000); chk("snap_hi", rdata, 32'h1);

    // Randomized phase
    tv = 64'h2_FFFF_F000;
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 199);
      tv = tv + 64'($urandom_range(0, 30));
      if (r < 4) tv = tv + 64'($urandom_range(0, 3000));
      rs = (r != 199);
      rq = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      case (a)
        3'd0: d = 32'($urandom_range(0, 7)) | 32'($urandom_range(0, 3) != 0);
        3'd1: d = tv[31:0] + 32'($urandom_range(0, 300));
        3'd2: d = tv[63:32];
        3'd3: d = 32'($urandom_range(0, 60));
        default: d = $urandom;
      endcase
      tick(rs, rq, w, a, d, tv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_alarm_ctrl.md
# timer_alarm_ctrl

Compare/alarm controller for the free-running 64-bit cycle timer. It watches the timer value, raises a registered interrupt when the timer reaches a programmed 64-bit compare value, and can re-arm itself periodically. It also gives 32-bit host readers a tear-free 64-bit time snapshot. It sits beside the timer on the controller's register bus, and its interrupt goes to the controller's event logic.

## Interface
Parameters:
- none; all widths are fixed.

Ports:
- `clk` — in, 1 — clock.
- `rst_n` — in, 1 — reset, synchronous, active-low.
- `time_i` — in, 64 — current timer value; free-running, wraps modulo 2^64.
- `req_i` — in, 1 — register access request, one cycle per access.
- `we_i` — in, 1 — 1 = write, 0 = read; qualified by `req_i`.
- `addr_i` — in, 3 — register word address.
- `wdata_i` — in, 32 — write data.
- `ack_o` — out, 1 — access done, exactly one cycle after `req_i`.
- `rdata_o` — out, 32 — read data, valid while `ack_o` = 1, otherwise 0.
- `irq_o` — out, 1 — alarm pending; level, registered.

## Operation
Register map (word addresses):
- **0 CTRL**
  - bit0 EN (rw).
  - bit1 PERIODIC (rw).
  - bit2 PEND (read 1 = pending; writing 1 clears it, writing 0 has no effect).
  - bits[4:3] STATE (ro).
  - other bits read 0.
- **1 CMP_LO** — write goes to a shadow register; the live compare value does not change. Read returns `cmp[31:0]`.
- **2 CMP_HI** — write commits `cmp <= {wdata_i, shadow_lo}` in one step. Read returns `cmp[63:32]`.
- **3 PERIOD** — 32-bit reload increment (rw).
- **4 TIME_LO** — read returns `time_i[31:0]` and, in the same cycle, latches `time_i[63:32]` into a snapshot register.
- **5 TIME_HI** — read returns the snapshot register. It changes only on a TIME_LO read.
- **6 FIRE_CNT** — number of fires, wraps at 2^32. Any write clears it to 0.
- **7 ID** — reads constant 32'h544D_5231. Writes are ignored.
- Writes to read-only fields are ignored.

State machine (STATE encoding: DISABLED=0, ARMED=1, FIRED=2):
- **DISABLED** → ARMED when EN becomes 1.
- **ARMED**: on a cycle where `time_i >= cmp` (unsigned 64-bit compare), a fire occurs:
  - PEND is set to 1.
  - FIRE_CNT increments by 1.
  - If PERIODIC = 1: `cmp <= cmp + {32'b0, PERIOD}`, modulo 2^64, and the state stays ARMED.
  - If PERIODIC = 0: the state goes to FIRED.
- **FIRED** → ARMED when a CMP_HI write occurs. Clearing PEND alone does not re-arm.
- From any state, EN = 0 → DISABLED. PEND and cmp keep their values.
- Periodic catch-up: if `cmp + PERIOD` is still ≤ `time_i`, the block fires again on the next cycle. There is one fire per cycle until it catches up, and each fire increments FIRE_CNT.

Boundary rules:
- PERIOD = 0 with PERIODIC = 1: the block fires every cycle while ARMED.
- Compare-value wrap is not special-cased. If `cmp + PERIOD` overflows past 2^64, the small wrapped value is already ≤ `time_i`, so the block fires on the next cycle.
- A fire and a PEND write-1-clear in the same cycle: the fire wins and PEND stays 1.
- A fire and a CMP_HI write in the same cycle: the write wins. `cmp` takes the written value, no period is added, and the state becomes ARMED. The fire itself still sets PEND and increments FIRE_CNT.
- A fire and a FIRE_CNT write in the same cycle: the count becomes 1.

## Timing
- All state is updated on the rising edge of `clk`.
- Reset values:
  - `ack_o` = 0, `rdata_o` = 0, `irq_o` = 0.
  - EN = 0, PERIODIC = 0, PEND = 0, STATE = DISABLED.
  - `cmp` = 64'hFFFF_FFFF_FFFF_FFFF, shadow_lo = 0, PERIOD = 0.
  - snapshot = 0, FIRE_CNT = 0.
- Reset applied in the middle of an access drops that access; no `ack_o` is produced for it.
- Register access:
  - `ack_o` and `rdata_o` are registered and appear exactly one cycle after `req_i` is sampled.
  - Back-to-back requests are allowed, and each one is acked on the following cycle.
  - A write takes effect in the same edge that sets `ack_o`.
- Fire timing:
  - A fire is evaluated on the `time_i` value sampled at an edge.
  - PEND and `irq_o` go high at that same edge, so `irq_o` is visible in the cycle after the matching `time_i`.
  - `irq_o` = PEND, independent of EN.
- Compare latency: a CMP_HI write at edge N changes `cmp` at edge N. The first possible fire against the new value is evaluated at edge N+1.
- TIME_LO read at edge N latches the upper 32 bits from the same `time_i` sample that supplies the returned lower 32 bits.

## Test plan
- **Reset:** drive `rst_n` = 0 for 2 cycles → all outputs 0; CTRL reads 0; CMP_LO and CMP_HI read 32'hFFFFFFFF; ID reads 32'h544D5231.
- **One-shot:**
  - Stimulus: write CMP_LO = 100, CMP_HI = 0, CTRL = 1, then ramp `time_i` upward from 90.
  - Required: `irq_o` rises in the cycle after `time_i` = 100; STATE = 2; FIRE_CNT = 1.
  - Then write CTRL = 5 (W1C PEND) → `irq_o` = 0; the block does not re-fire.
- **Periodic:**
  - Stimulus: CMP = 1000, PERIOD = 50, CTRL = 3, `time_i` incrementing.
  - Required: fires at 1000, 1050 and 1100; after these, FIRE_CNT = 3 and CMP_LO = 1150.
  - Then jump `time_i` to 1300 → 4 fires on consecutive cycles; CMP_LO ends at 1350.
- **Atomic CMP update:**
  - Stimulus: while ARMED, write CMP_LO = 5 with `time_i` = 10, then write CMP_HI = 1.
  - Required: no fire between the two writes; `cmp` = 64'h1_0000_0005.
- **Snapshot:** `time_i` = 64'h0000_0001_FFFF_FFFF at the TIME_LO read, then 64'h0000_0002_0000_0000 at the TIME_HI read → reads return FFFFFFFF, then 00000001.
- **Collisions:**
  - A PEND clear in the same cycle as a fire → PEND stays 1.
  - A FIRE_CNT write in the same cycle as a fire → FIRE_CNT = 1.
  - EN = 0 mid-ARMED → STATE = 0 and no further fires.
